serial_frame_rx: RTL
====================

Name: serial_frame_rx

Overview:
Downstream stage of the trigger-driven serial producer: consumes its 1-bit `data_o` stream and reassembles it into parallel words. Detects a start bit, shifts in DATA_W payload bits LSB-first, checks the stop bit, and presents the word through a valid/ready handshake. A one-entry holding register decouples framing from the consumer. Overrun and framing errors are flagged as sticky status bits.

Parameters:
DATA_W, 8, payload bits per frame (legal range 1..32)
IDLE_LVL, 1'b0, line level while idle; start bit = ~IDLE_LVL, stop bit = IDLE_LVL

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
bit_en  input  1  line sampled only on cycles where bit_en=1
serial_in  input  1  serial stream (producer's data_o)
data_out  output  DATA_W  received word, held stable while valid_out=1
valid_out  output  1  data_out holds an unconsumed word
ready_in  input  1  consumer accepts the word when valid_out&ready_in
busy  output  1  frame in progress (state != IDLE)
frame_err  output  1  sticky: stop bit was wrong
overrun  output  1  sticky: completed frame dropped because holding register was full
err_clr  input  1  synchronous clear of frame_err and overrun

Behaviour:
- Reset (async assert, sync release): state=IDLE, shift reg=0, bit counter=0, data_out=0, valid_out=0, busy=0, frame_err=0, overrun=0.
- Cycles with bit_en=0 freeze the state, shift register and bit counter; the handshake and err_clr still act.
- FSM states (enum in package): IDLE, DATA, [PARITY], STOP.
  - IDLE: bit_en & serial_in==~IDLE_LVL -> DATA, counter=0.
  - DATA: each bit_en shifts serial_in in at the MSB side, so the first bit received lands in bit 0. After DATA_W bits -> STOP (or PARITY).
  - STOP: on bit_en, sample the stop bit -> IDLE. If stop==IDLE_LVL and the holding register is free, load data_out and set valid_out the next cycle. Stop wrong: set frame_err and discard the word.
- Holding register counts as free if valid_out=0, or valid_out&ready_in in the same cycle (accept and reload in one cycle, no bubble).
- Full at STOP: discard the word, set overrun; data_out is unchanged.
- Latency: valid_out rises 1 clk after the bit_en cycle that samples a good stop bit.
- valid_out drops the cycle after valid_out&ready_in unless it is reloaded in that same cycle.
- A start is accepted in IDLE on the bit_en cycle right after STOP; back-to-back frames need no idle gap.
- err_clr and a new error in the same cycle: the error wins (bit stays 1).
- Counter width is $clog2(DATA_W+1); no wrap, because the counter resets on each frame.
- Reset mid-frame aborts the frame silently; no flags are set.

Optional Feature:
- Macro SERIAL_FRAME_RX_PARITY_EN.
- Defined: a PARITY state follows DATA and samples one even-parity bit (XOR of payload ^ parity must be 0). Mismatch sets frame_err and drops the word, even if the stop bit is good. Frame length becomes DATA_W+3 bits.
- Undefined: no PARITY state and no parity logic; frame length is DATA_W+2 bits.

Decomposition:
- Package serial_frame_pkg: state enum rx_state_t {IDLE, DATA, PARITY, STOP}, and a function even_parity(). PARITY is always present in the enum and is unreachable when the macro is undefined.
- Sub-module serial_frame_hold: the one-entry valid/ready holding register. Inputs load/load_data; outputs data_out/valid_out/free. It is reused by the future transmit-side skid buffer.

Test Plan:
- Single frame, bit_en=1 every cycle, DATA_W=8. Stimulus: bits 1, 1,0,1,0,0,1,0,1, 0 (start, payload LSB-first, stop), ready_in=1. Expect data_out=8'hA5, valid_out high for 1 clk, 1 clk after the stop sample; frame_err=0.
- Back-to-back frames 8'h3C then 8'hC3 with no idle gap, ready_in=1. Expect two valid pulses with the correct data and busy low for at most 1 cycle between frames.
- ready_in=0 and two frames sent (8'h11, 8'h22). Expect data_out=8'h11 held, overrun=1. After ready_in=1, one transfer of 8'h11, then valid_out=0.
- Stop bit driven to 1 for payload 8'hFF. Expect no valid_out and frame_err=1. Pulse err_clr: frame_err returns to 0 the next clk.
- bit_en toggled every other cycle during frame 8'h5A. Expect the same result as continuous bit_en, and state held on bit_en=0 cycles.
- Assert rst mid-DATA, release, then send 8'h81. Expect outputs 0 immediately on assert, then clean reception of 8'h81. With the macro defined, a bad parity bit on 8'h81 gives frame_err=1 and no valid_out.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// ============================================================================
//  Module      : serial_frame_pkg
//  Description : Shared types and helpers for the serial frame receiver.
//                PARITY is only reachable with SERIAL_FRAME_RX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_frame_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_t;

   // Even-parity bit for a payload zero-extended to 32 bits.
   function automatic logic even_parity(input logic [31:0] payload);
      return ^payload;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_frame_hold.sv
// ============================================================================
//  Module      : serial_frame_hold
//  Description : One-entry valid/ready holding register; accepts a load in
//                the same cycle the current word is consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_hold #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              ready_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              free
);

   assign free = ~valid_out | ready_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out  <= '0;
         valid_out <= 1'b0;
      end else if (load) begin
         data_out  <= load_data;
         valid_out <= 1'b1;
      end else if (valid_out && ready_in) begin
         valid_out <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/serial_frame_rx.sv
// ============================================================================
//  Module      : serial_frame_rx
//  Description : Serial-to-parallel frame receiver (start, LSB-first payload,
//                optional even parity via SERIAL_FRAME_RX_PARITY_EN, stop).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_rx
   import serial_frame_pkg::*;
#(
   parameter int   DATA_W   = 8,
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_en,
   input  logic              serial_in,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   input  logic              ready_in,
   output logic              busy,
   output logic              frame_err,
   output logic              overrun,
   input  logic              err_clr
);

   localparam int c_CNT_W = $clog2(DATA_W + 1);

   rx_state_t           r_state, w_state_nxt;
   logic [DATA_W-1:0]   r_shift, w_shift_nxt;
   logic [c_CNT_W-1:0]  r_cnt;
   logic                w_last_bit;
   logic                w_stop_smp;
   logic                w_good;
   logic                w_free;
   logic                w_load;

   assign w_last_bit = (r_cnt == c_CNT_W'(DATA_W - 1));
   assign busy       = (r_state != IDLE);

   always_comb begin
      w_state_nxt = r_state;
      w_stop_smp  = 1'b0;
      case (r_state)
         IDLE:    if (bit_en && (serial_in == ~IDLE_LVL)) w_state_nxt = DATA;
`ifdef SERIAL_FRAME_RX_PARITY_EN
         DATA:    if (bit_en && w_last_bit) w_state_nxt = PARITY;
`else
         DATA:    if (bit_en && w_last_bit) w_state_nxt = STOP;
`endif
         PARITY:  if (bit_en) w_state_nxt = STOP;
         STOP: begin
            if (bit_en) begin
               w_state_nxt = IDLE;
               w_stop_smp  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // New bits enter at the MSB so the first payload bit ends up in bit 0.
   always_comb begin
      w_shift_nxt             = r_shift >> 1;
      w_shift_nxt[DATA_W-1]   = serial_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= '0;
         r_cnt   <= '0;
      end else if (bit_en) begin
         if (r_state == IDLE) begin
            r_cnt <= '0;
         end else if (r_state == DATA) begin
            r_cnt   <= r_cnt + c_CNT_W'(1);
            r_shift <= w_shift_nxt;
         end
      end
   end

`ifdef SERIAL_FRAME_RX_PARITY_EN
   logic r_par_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_par_ok <= 1'b0;
      else if (bit_en && (r_state == PARITY))
         r_par_ok <= (even_parity(32'(r_shift)) == serial_in);
   end

   assign w_good = (serial_in == IDLE_LVL) & r_par_ok;
`else
   assign w_good = (serial_in == IDLE_LVL);
`endif

   assign w_load = w_stop_smp & w_good & w_free;

   // A fresh error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (w_stop_smp && !w_good)      frame_err <= 1'b1;
         else if (err_clr)               frame_err <= 1'b0;
         if (w_stop_smp && w_good && !w_free) overrun <= 1'b1;
         else if (err_clr)               overrun   <= 1'b0;
      end
   end

   serial_frame_hold #(
      .DATA_W (DATA_W)
   ) u_hold (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load),
      .load_data (r_shift),
      .ready_in  (ready_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .free      (w_free)
   );

endmodule

`default_nettype wire
